// File: rtl/line_buffer_7row.sv
// -----------------------------------------------------------------------------
// line_buffer_7row
//
// Vertical line buffer for the 7x7 noise-filter window. For every accepted
// raster pixel it presents seven vertically aligned pixels from the same
// column: the current line (row0) and the six preceding lines (row1..row6).
// Each row output feeds one 7-tap horizontal shift register downstream.
//
// Six line memories, one line each, are chained at a shared column address.
// Every accepted pixel reads all six memories at the current column and then
// writes the pixel into memory 0. Each older value moves one memory further
// down the chain. Because every read returns the value stored before this
// cycle's write, the cascade shifts the column one line deeper.
//
// Ports:
//   clk         system clock, rising edge
//   rst         asynchronous active-low reset
//   sof         start of frame, qualified by din_valid, marks pixel (0,0)
//   din_valid   din carries a pixel this cycle
//   din         raster pixel, left-to-right, top-to-bottom
//   row0        current-line pixel (registered din)
//   row1..row6  same column, 1..6 lines earlier
//   dout_valid  row outputs, col_out and win_ok were updated this cycle
//   col_out     column index of the current row outputs
//   win_ok      all seven rows hold real lines of the current frame
// -----------------------------------------------------------------------------
module line_buffer_7row #(
    parameter int IMG_WIDTH = 640,
    parameter int DATA_W    = 8,
    parameter int COL_W     = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sof,
    input  logic              din_valid,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] row0,
    output logic [DATA_W-1:0] row1,
    output logic [DATA_W-1:0] row2,
    output logic [DATA_W-1:0] row3,
    output logic [DATA_W-1:0] row4,
    output logic [DATA_W-1:0] row5,
    output logic [DATA_W-1:0] row6,
    output logic              dout_valid,
    output logic [COL_W-1:0]  col_out,
    output logic              win_ok
);

    localparam int              NMEM     = 6;
    localparam logic [COL_W-1:0] LAST_COL = COL_W'(IMG_WIDTH - 1);
    localparam logic [2:0]      LINE_MAX = 3'd6;

    logic [COL_W-1:0]  col_r;
    logic [2:0]        line_cnt_r;
    logic [COL_W-1:0]  col_eff_s;
    logic [2:0]        line_eff_s;
    logic [COL_W-1:0]  col_nxt_s;
    logic [2:0]        line_nxt_s;

    // Line memories are deliberately left out of reset so they map onto RAM.
    logic [DATA_W-1:0] lm_r [NMEM][IMG_WIDTH];
    logic [DATA_W-1:0] rd_s [NMEM];

    // Effective column/line for this pixel: sof forces pixel (0,0) of a new frame.
    always_comb begin
        col_eff_s  = col_r;
        line_eff_s = line_cnt_r;
        if (sof) begin
            col_eff_s  = {COL_W{1'b0}};
            line_eff_s = 3'd0;
        end else begin
            col_eff_s  = col_r;
            line_eff_s = line_cnt_r;
        end
    end

    // Next counter values: the column wraps at the line end, and the line count saturates at six.
    always_comb begin
        col_nxt_s  = col_eff_s;
        line_nxt_s = line_eff_s;
        if (col_eff_s == LAST_COL) begin
            col_nxt_s = {COL_W{1'b0}};
            if (line_eff_s == LINE_MAX) begin
                line_nxt_s = LINE_MAX;
            end else begin
                line_nxt_s = line_eff_s + 3'd1;
            end
        end else begin
            col_nxt_s  = col_eff_s + COL_W'(1);
            line_nxt_s = line_eff_s;
        end
    end

    // Read all six memories at the current column, returning data from before this cycle's write.
    always_comb begin
        for (int k = 0; k < NMEM; k++) begin
            rd_s[k] = lm_r[k][col_eff_s];
        end
    end

    // Write cascade at the shared address: the new pixel goes into memory 0, and each old value moves down one memory.
    always_ff @(posedge clk) begin
        if (din_valid) begin
            lm_r[0][col_eff_s] <= din;
            for (int k = 1; k < NMEM; k++) begin
                lm_r[k][col_eff_s] <= rd_s[k-1];
            end
        end
    end

    // Column and line-fill counters advance only on accepted pixels.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            col_r      <= {COL_W{1'b0}};
            line_cnt_r <= 3'd0;
        end else if (din_valid) begin
            col_r      <= col_nxt_s;
            line_cnt_r <= line_nxt_s;
        end
    end

    // Registered window outputs: update on accepted pixels, hold during stalls.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            row0       <= {DATA_W{1'b0}};
            row1       <= {DATA_W{1'b0}};
            row2       <= {DATA_W{1'b0}};
            row3       <= {DATA_W{1'b0}};
            row4       <= {DATA_W{1'b0}};
            row5       <= {DATA_W{1'b0}};
            row6       <= {DATA_W{1'b0}};
            col_out    <= {COL_W{1'b0}};
            win_ok     <= 1'b0;
            dout_valid <= 1'b0;
        end else begin
            dout_valid <= din_valid;
            if (din_valid) begin
                row0    <= din;
                row1    <= rd_s[0];
                row2    <= rd_s[1];
                row3    <= rd_s[2];
                row4    <= rd_s[3];
                row5    <= rd_s[4];
                row6    <= rd_s[5];
                col_out <= col_eff_s;
                win_ok  <= (line_eff_s == LINE_MAX);
            end
        end
    end

endmodule
